// File: rtl/graph_edge_server.sv
// Adjacency-list responder: loads a directed graph edge by edge, then serves
// start/end nodes and per-node successor streams to the path-counting core.
module graph_edge_server #(
  parameter int PARAM_NODE_IDX_WIDTH = 10,
  parameter int PARAM_COUNTER_WIDTH  = 5,
  parameter int PARAM_EDGE_DEPTH     = 2048
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            load_valid,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0] load_src_idx,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0] load_dst_idx,
  input  logic                            load_commit,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0] cfg_start_node,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0] cfg_end_node,
  output logic                            load_ready,
  output logic                            loaded,
  input  logic                            start_run,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0] node_idx_reg,
  input  logic                            rd_next_node_reg,
  input  logic                            done_reg,
  output logic [PARAM_NODE_IDX_WIDTH-1:0] next_node_idx,
  output logic [PARAM_COUNTER_WIDTH-1:0]  next_node_counter,
  output logic [3:0]                      err_flags
);

  localparam int NW = PARAM_NODE_IDX_WIDTH;
  localparam int CW = PARAM_COUNTER_WIDTH;
  localparam int DEPTH = PARAM_EDGE_DEPTH;
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int NN = 1 << NW;

  typedef enum logic [2:0] {
    S_LOAD, S_READY, S_SEND_START, S_SEND_END, S_SERVE_FETCH, S_SERVE_STREAM, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NW-1:0]   last_src_q, last_src_d;
  logic            have_src_q, have_src_d;
  logic [NW-1:0]   start_node_q, start_node_d;
  logic [NW-1:0]   end_node_q, end_node_d;
  logic [NW-1:0]   next_node_idx_q, next_node_idx_d;
  logic [CW-1:0]   next_node_counter_q, next_node_counter_d;
  logic [3:0]      err_flags_q, err_flags_d;

  logic [CW-1:0]   degree_q [NN];
  logic            seen_q   [NN];
  logic [AW-1:0]   offset_q [NN];
  logic [NW-1:0]   edge_q   [DEPTH];

  logic            ld_accept;
  logic            ld_new_src;
  logic [CW-1:0]   src_deg;
  logic [CW-1:0]   fetch_deg;
  logic [AW-1:0]   fetch_off;

  assign src_deg    = degree_q[load_src_idx];
  assign ld_new_src = !have_src_q || (load_src_idx != last_src_q);
  assign fetch_deg  = degree_q[node_idx_reg];
  assign fetch_off  = offset_q[node_idx_reg];

  always_comb begin
    state_d             = state_q;
    ptr_d               = ptr_q;
    last_src_d          = last_src_q;
    have_src_d          = have_src_q;
    start_node_d        = start_node_q;
    end_node_d          = end_node_q;
    next_node_idx_d     = next_node_idx_q;
    next_node_counter_d = next_node_counter_q;
    err_flags_d         = err_flags_q;
    ld_accept           = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (load_commit) begin
          start_node_d        = cfg_start_node;
          end_node_d          = cfg_end_node;
          next_node_idx_d     = cfg_start_node;
          next_node_counter_d = '0;
          state_d             = S_READY;
        end else if (load_valid) begin
          if (ptr_q == PW'(DEPTH)) begin
            err_flags_d[0] = 1'b1;
          end else if (src_deg == {CW{1'b1}}) begin
            err_flags_d[1] = 1'b1;
          end else begin
            ld_accept  = 1'b1;
            ptr_d      = ptr_q + PW'(1);
            last_src_d = load_src_idx;
            have_src_d = 1'b1;
            // A source reappearing after another one breaks offset contiguity
            if (ld_new_src && seen_q[load_src_idx]) err_flags_d[2] = 1'b1;
          end
        end
      end
      S_READY: begin
        if (start_run) state_d = S_SEND_START;
      end
      default: begin
        // Serving states freeze together with the core while start_run is low
        if (start_run) begin
          case (state_q)
            S_SEND_START: begin
              state_d         = S_SEND_END;
              next_node_idx_d = end_node_q;
            end
            S_SEND_END: state_d = S_SERVE_FETCH;
            S_SERVE_FETCH: begin
              if (done_reg) begin
                state_d = S_DONE;
              end else if (rd_next_node_reg) begin
                if (fetch_deg != '0) begin
                  next_node_idx_d     = edge_q[fetch_off];
                  next_node_counter_d = fetch_deg;
                  ptr_d               = PW'(fetch_off) + PW'(1);
                  state_d             = S_SERVE_STREAM;
                end else begin
                  next_node_idx_d     = {NW{1'b1}};
                  next_node_counter_d = '0;
                  err_flags_d[3]      = 1'b1;
                  state_d             = S_DONE;
                end
              end
            end
            S_SERVE_STREAM: begin
              if (next_node_counter_q == CW'(1)) begin
                state_d = S_SERVE_FETCH;
              end else begin
                next_node_idx_d     = edge_q[ptr_q[AW-1:0]];
                next_node_counter_d = next_node_counter_q - CW'(1);
                ptr_d               = ptr_q + PW'(1);
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q             <= S_LOAD;
      ptr_q               <= '0;
      last_src_q          <= '0;
      have_src_q          <= 1'b0;
      start_node_q        <= '0;
      end_node_q          <= '0;
      next_node_idx_q     <= '0;
      next_node_counter_q <= '0;
      err_flags_q         <= '0;
    end else begin
      state_q             <= state_d;
      ptr_q               <= ptr_d;
      last_src_q          <= last_src_d;
      have_src_q          <= have_src_d;
      start_node_q        <= start_node_d;
      end_node_q          <= end_node_d;
      next_node_idx_q     <= next_node_idx_d;
      next_node_counter_q <= next_node_counter_d;
      err_flags_q         <= err_flags_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NN; i++) begin
        degree_q[i] <= '0;
        seen_q[i]   <= 1'b0;
        offset_q[i] <= '0;
      end
      for (int j = 0; j < DEPTH; j++) edge_q[j] <= '0;
    end else if (ld_accept) begin
      edge_q[ptr_q[AW-1:0]]  <= load_dst_idx;
      degree_q[load_src_idx] <= src_deg + CW'(1);
      seen_q[load_src_idx]   <= 1'b1;
      if (ld_new_src) offset_q[load_src_idx] <= ptr_q[AW-1:0];
    end
  end

  assign load_ready        = (state_q == S_LOAD);
  assign loaded            = (state_q != S_LOAD);
  assign next_node_idx     = next_node_idx_q;
  assign next_node_counter = next_node_counter_q;
  assign err_flags         = err_flags_q;

endmodule

// File: doc/graph_edge_server.md
# graph_edge_server

Adjacency-list responder for the path-counting core. Holds a directed graph loaded edge by edge, then answers the core's node fetches. It first presents the start and end node indices. It then streams each requested node's successor list one entry per cycle, with a down-counter. It is the supplier end of the `node_idx_reg` / `rd_next_node_reg` → `next_node_idx` / `next_node_counter` interface.

## Interface
Parameters:
- PARAM_NODE_IDX_WIDTH, 10: node index width; node table has 2^W entries.
- PARAM_COUNTER_WIDTH, 5: width of `next_node_counter` and of each stored out-degree.
- PARAM_EDGE_DEPTH, 2048: edge memory entries (power of 2).

Ports:
- clk  in  1  clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- load_valid  in  1  edge write strobe.
- load_src_idx  in  NODE_IDX_WIDTH  edge source node.
- load_dst_idx  in  NODE_IDX_WIDTH  edge destination node.
- load_commit  in  1  ends loading; samples cfg_* nodes.
- cfg_start_node  in  NODE_IDX_WIDTH  start node.
- cfg_end_node  in  NODE_IDX_WIDTH  end node.
- load_ready  out  1  high in LOAD state.
- loaded  out  1  high in READY and every later state.
- start_run  in  1  run enable, shared with the core.
- node_idx_reg  in  NODE_IDX_WIDTH  node requested by the core.
- rd_next_node_reg  in  1  core read enable.
- done_reg  in  1  core finished.
- next_node_idx  out  NODE_IDX_WIDTH  registered; start node, end node, or successor.
- next_node_counter  out  COUNTER_WIDTH  registered; successors remaining, including the current one.
- err_flags  out  4  sticky error flags:
  - bit 0: edge memory overflow
  - bit 1: degree saturation
  - bit 2: non-contiguous source
  - bit 3: zero-degree fetch

## Operation
- State encoding: 3 bits. States are LOAD, READY, SEND_START, SEND_END, SERVE_FETCH, SERVE_STREAM, DONE.
- Reset:
  - State goes to LOAD.
  - Every output is 0, except `load_ready`, which is 1.
  - All degree, seen-bit, offset and edge arrays are cleared.
  - Edge write pointer is 0.
- LOAD, on `load_valid`:
  - If `load_src_idx` differs from the last source, or this is the first edge, record `offset[src]` = write pointer.
  - If that new source already has its seen bit set, set err_flags[2]; the offset is still overwritten.
  - Set `seen[src]`.
  - Write `edge[ptr]` = dst, increment `degree[src]`, increment ptr.
- LOAD limits:
  - Edge memory full (ptr == EDGE_DEPTH): the edge is dropped and err_flags[0] is set.
  - Degree at its maximum (2^COUNTER_WIDTH-1): the edge is dropped and err_flags[1] is set.
- LOAD, on `load_commit`:
  - Latch `cfg_start_node` and `cfg_end_node`, then go to READY.
  - `load_commit` has priority over a same-cycle `load_valid`; that edge is dropped.
- Loads outside LOAD are ignored. Reloading requires a reset.
- READY: `next_node_idx` = start node and counter = 0. On `start_run` go to SEND_START.
- SEND_START: outputs hold the start node. Next state is SEND_END, with `next_node_idx` loaded with the end node.
- SEND_END: outputs hold the end node. Next state is SERVE_FETCH.
- SERVE_FETCH:
  - If `done_reg` is high, go to DONE.
  - Else, if `rd_next_node_reg` is high, take n = `node_idx_reg`:
    - degree[n] > 0: load `next_node_idx` = edge[offset[n]] and counter = degree[n], set ptr = offset[n]+1, go to SERVE_STREAM.
    - degree[n] = 0: load `next_node_idx` = all-ones and counter = 0, set err_flags[3], go to DONE.
  - Otherwise hold.
- SERVE_STREAM:
  - Counter == 1: go to SERVE_FETCH; outputs hold.
  - Otherwise: `next_node_idx` = edge[ptr], counter decrements by 1, ptr increments, stay.
- DONE: terminal until reset; outputs hold.
- From SEND_START onward, all state and output updates are gated by `start_run`. With `start_run` low the block freezes, matching the core's freeze.

## Timing
- Cycle A: `start_run` first high while in READY.
- Cycle A+1 (SEND_START): start node is visible; the core samples it.
- Cycle A+2 (SEND_END): end node is visible.
- Cycle A+3 (SERVE_FETCH): `node_idx_reg` must be valid.
- First successor, with counter = degree, is visible one cycle after each SERVE_FETCH cycle.
- Later successors follow one per cycle.
- The cycle after counter = 1 is visible is always a SERVE_FETCH cycle. A node of degree d therefore costs d+1 cycles.
- Offset, degree and edge reads are combinational from register arrays; there are no read-latency bubbles.
- Reset asserted mid-run returns the block to LOAD immediately. All graph contents and err_flags are lost.

## Test plan
- Load 0→1, 0→2, 1→3, 2→3, 3→4, with start 0 and end 4, then commit. Run against the core model.
  - Required output stream: 0; 4; (1,c2) (2,c1); (3,c1); (3,c1); (4,c1).
  - Core `part1_ans` = 2; the block ends in DONE with err_flags = 0.
- Hold `start_run` low for 3 cycles in the middle of the 0→{1,2} stream. Outputs and state freeze, then resume with (2,c1).
- Default widths: load 31 edges from source 5, then a 32nd. The 32nd is dropped; err_flags[1] = 1; fetching node 5 gives counter 31 on the first entry.
- PARAM_EDGE_DEPTH=8: load 9 edges. err_flags[0] = 1; the 9th is absent from the stream.
- Load sources 1, 2, 1 in that order. err_flags[2] = 1 after the third write.
- Request a node with no edges. Required response: next_node_idx = 10'h3FF, counter 0, err_flags[3] = 1, state DONE.
- Reset mid-SERVE_STREAM. All outputs become 0 and `load_ready` = 1. After reloading the first graph, the first scenario's stream repeats exactly.
